i2c_master_engine: RTL and testbench

Synthesisable, parametrised I2C master bit/byte engine: the RTL successor to the behavioural I2C master model used in simulation. Executes one command at a time (START/repeated START, STOP, WRITE byte, READ byte) from a valid/ready command port, drives SCL/SDA open-drain, and returns ACK, read data and arbitration status on a response strobe. Sits between a host sequencer (e.g. a Wishbone register front end) and the I2C pads. It also serves as a bench master against the i2c_to_wb slave.

---
 rtl/i2c_master_pkg.sv | 39 +++
 rtl/i2c_master_engine_sync.sv | 25 ++
 rtl/i2c_master_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_master_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_pkg.sv
// Shared types for the I2C master engine: command opcodes, FSM states,
// bit quarter phases and the legal CLK_DIV range.
package i2c_master_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_STOP  = 2'd1,
        OP_WRITE = 2'd2,
        OP_READ  = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STOP,
        ST_WBIT,
        ST_WACK,
        ST_RBIT,
        ST_RACK,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} qphase_t;

    localparam int unsigned CLK_DIV_MIN = 2;
    localparam int unsigned CLK_DIV_MAX = 4095;

    function automatic qphase_t next_phase(input qphase_t p);
        qphase_t n;
        case (p)
            Q0: n = Q1;
            Q1: n = Q2;
            Q2: n = Q3;
            Q3: n = Q0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/i2c_master_engine_sync.sv
// SYNC_STAGES-deep synchroniser for the raw SCL/SDA pad inputs; resets to
// the released (high) bus level.
module i2c_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] d_i,
    output logic [1:0] q_o
);

    logic [1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) stage[i] <= '1;
        end else begin
            stage[0] <= d_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q_o = stage[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_master_engine.sv
// I2C master bit/byte engine: one START/STOP/WRITE/READ command at a time,
// open-drain SCL/SDA. Clock stretching support: define I2C_MASTER_STRETCH_EN.
module i2c_master_engine
    import i2c_master_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 125,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_ack_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_nack_o,
    output logic       rsp_arb_lost_o,
    output logic       rsp_err_o,
    output logic       busy_o,
    input  logic       i2c_clk_i,
    input  logic       i2c_data_i,
    output logic       i2c_clk_oe_o,
    output logic       i2c_data_oe_o
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_bad_div
        $error("CLK_DIV out of legal range");
    end

    state_t        state, state_n;
    qphase_t       phase, phase_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n, rdata, rdata_n;
    logic          ack, ack_n, clk_oe, clk_oe_n, data_oe, data_oe_n;
    logic          busy, busy_n, nack, nack_n, arb, arb_n, err, err_n;
    logic [1:0]    sync_q;
    logic          scl_s, sda_s, hold, q_end, q_first;

    i2c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     ({i2c_clk_i, i2c_data_i}),
        .q_o     (sync_q)
    );
    assign scl_s = sync_q[1];
    assign sda_s = sync_q[0];

`ifdef I2C_MASTER_STRETCH_EN
    assign hold = (phase == Q2) && !scl_s;
`else
    logic scl_unused;
    assign hold       = 1'b0;
    assign scl_unused = scl_s;
`endif

    assign q_end   = (cnt == '0) && !hold;
    assign q_first = (cnt == RELOAD);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            phase   <= Q0;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            rdata   <= '0;
            ack     <= 1'b0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            busy    <= 1'b0;
            nack    <= 1'b0;
            arb     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            rdata   <= rdata_n;
            ack     <= ack_n;
            clk_oe  <= clk_oe_n;
            data_oe <= data_oe_n;
            busy    <= busy_n;
            nack    <= nack_n;
            arb     <= arb_n;
            err     <= err_n;
        end
    end

    // SCL follows quarter boundaries; SDA updates one cycle into its quarter
    // so data always changes at least a clock after SCL falls.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        rdata_n   = rdata;
        ack_n     = ack;
        clk_oe_n  = clk_oe;
        data_oe_n = data_oe;
        busy_n    = busy;
        nack_n    = nack;
        arb_n     = arb;
        err_n     = err;
        case (state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    nack_n    = 1'b0;
                    arb_n     = 1'b0;
                    err_n     = !busy && (cmd_op_i != OP_START);
                    phase_n   = Q0;
                    cnt_n     = RELOAD;
                    bit_cnt_n = '0;
                    case (cmd_op_t'(cmd_op_i))
                        OP_START: state_n = ST_START;
                        OP_STOP:  state_n = busy ? ST_STOP : ST_RESP;
                        OP_WRITE: begin
                            state_n = busy ? ST_WBIT : ST_RESP;
                            shreg_n = cmd_data_i;
                        end
                        OP_READ: begin
                            state_n = busy ? ST_RBIT : ST_RESP;
                            ack_n   = cmd_ack_i;
                        end
                    endcase
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: begin
                if (q_first) begin
                    if (phase == Q0) begin
                        case (state)
                            ST_START: data_oe_n = 1'b0;
                            ST_STOP:  data_oe_n = 1'b1;
                            ST_WBIT:  data_oe_n = !shreg[7];
                            ST_RACK:  data_oe_n = ack;
                            default:  data_oe_n = 1'b0;
                        endcase
                    end else if (phase == Q2) begin
                        if (state == ST_START) data_oe_n = 1'b1;
                        if (state == ST_STOP)  data_oe_n = 1'b0;
                    end
                end
                if (q_end) begin
                    cnt_n   = RELOAD;
                    phase_n = next_phase(phase);
                    case (phase)
                        Q0: if (state == ST_START || state == ST_STOP) clk_oe_n = 1'b0;
                        Q1: if (state != ST_START && state != ST_STOP) clk_oe_n = 1'b0;
                        Q2: begin
                            case (state)
                                ST_START: clk_oe_n = 1'b1;
                                ST_WBIT: begin
                                    if (shreg[7] && !sda_s) begin
                                        state_n   = ST_RESP;
                                        clk_oe_n  = 1'b0;
                                        data_oe_n = 1'b0;
                                        arb_n     = 1'b1;
                                        busy_n    = 1'b0;
                                    end
                                end
                                ST_WACK: nack_n  = sda_s;
                                ST_RBIT: shreg_n = {shreg[6:0], sda_s};
                                default: ;
                            endcase
                        end
                        Q3: begin
                            case (state)
                                ST_START: begin
                                    state_n = ST_RESP;
                                    busy_n  = 1'b1;
                                end
                                ST_STOP: begin
                                    state_n = ST_RESP;
                                    busy_n  = 1'b0;
                                end
                                ST_WBIT: begin
                                    clk_oe_n = 1'b1;
                                    shreg_n  = {shreg[6:0], 1'b0};
                                    if (bit_cnt == 3'd7) state_n = ST_WACK;
                                    else bit_cnt_n = bit_cnt + 3'd1;
                                end
                                ST_RBIT: begin
                                    clk_oe_n = 1'b1;
                                    if (bit_cnt == 3'd7) state_n = ST_RACK;
                                    else bit_cnt_n = bit_cnt + 3'd1;
                                end
                                ST_RACK: begin
                                    clk_oe_n = 1'b1;
                                    rdata_n  = shreg;
                                    state_n  = ST_RESP;
                                end
                                default: begin
                                    clk_oe_n = 1'b1;
                                    state_n  = ST_RESP;
                                end
                            endcase
                        end
                    endcase
                end else if (!hold) begin
                    cnt_n = cnt - CW'(1);
                end
            end
        endcase
    end

    assign cmd_ready_o    = (state == ST_IDLE);
    assign rsp_valid_o    = (state == ST_RESP);
    assign rsp_data_o     = rdata;
    assign rsp_nack_o     = nack;
    assign rsp_arb_lost_o = arb;
    assign rsp_err_o      = err;
    assign busy_o         = busy;
    assign i2c_clk_oe_o   = clk_oe;
    assign i2c_data_oe_o  = data_oe;

endmodule

// File: tb/tb_i2c_master_engine.sv
// Directed/randomised bench for i2c_master_engine with a bus-level slave and
// monitor model (open-drain wired-AND of master and slave pull-downs).
`timescale 1ns/1ps
module tb_i2c_master_engine;
    import i2c_master_pkg::*;

    localparam int unsigned D     = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned LIMIT = 3000;
`ifdef I2C_MASTER_STRETCH_EN
    localparam int unsigned SX = SYNC;
`else
    localparam int unsigned SX = 0;
`endif
    localparam int unsigned LAT_SS   = 4 * D + 1;
    localparam int unsigned LAT_BYTE = 9 * 4 * D + 1 + 9 * SX;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ack = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ready, rsp_valid, rsp_nack, rsp_arb, rsp_err, busy, clk_oe, data_oe;
    logic [7:0] rsp_data;
    logic       scl_bus, sda_bus, sl_sda_low, sl_scl_low = 1'b0;

    assign scl_bus = !((clk_oe === 1'b1) || sl_scl_low);
    assign sda_bus = !((data_oe === 1'b1) || sl_sda_low);

    i2c_master_engine #(.CLK_DIV(D), .SYNC_STAGES(SYNC)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_op_i       (cmd_op),
        .cmd_data_i     (cmd_data),
        .cmd_ack_i      (cmd_ack),
        .rsp_valid_o    (rsp_valid),
        .rsp_data_o     (rsp_data),
        .rsp_nack_o     (rsp_nack),
        .rsp_arb_lost_o (rsp_arb),
        .rsp_err_o      (rsp_err),
        .busy_o         (busy),
        .i2c_clk_i      (scl_bus),
        .i2c_data_i     (sda_bus),
        .i2c_clk_oe_o   (clk_oe),
        .i2c_data_oe_o  (data_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Bus monitor: SDA level at each SCL rise, START/STOP conditions, bit index.
    int   idx = -1, starts = 0, stops = 0;
    logic bitq[$];
    always @(posedge scl_bus) bitq.push_back(sda_bus);
    always @(negedge sda_bus) if (scl_bus) begin starts++; idx = -1; end
    always @(posedge sda_bus) if (scl_bus) begin stops++; idx = -1; end
    always @(negedge scl_bus) idx = (idx < 0 || idx >= 8) ? 0 : idx + 1;

    typedef enum {M_NONE, M_WACK, M_READ, M_ARB} smode_t;
    smode_t     mode = M_NONE;
    logic       slave_ack = 1'b1;
    logic [7:0] rd_byte = 8'd0;
    int         arb_idx = 1;
    always_comb begin
        sl_sda_low = 1'b0;
        case (mode)
            M_WACK:  sl_sda_low = (idx == 8) && slave_ack;
            M_READ:  if (idx >= 0 && idx < 8) sl_sda_low = !rd_byte[7 - idx];
            M_ARB:   sl_sda_low = (idx == arb_idx);
            default: ;
        endcase
    end

    int vectors = 0, miscompares = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] qval();
        logic [15:0] v = '0;
        foreach (bitq[i]) v = {v[14:0], bitq[i]};
        return v;
    endfunction

    int         acc = 0, lat = 0;
    logic       r_nack, r_arb, r_err, any_oe;
    logic [7:0] r_data;

    task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic a);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_ack = a;
        while (!cmd_ready && t < LIMIT) begin @(negedge clk); t++; end
        chk("accept", t < LIMIT, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_rsp();
        @(negedge clk);
        any_oe = clk_oe | data_oe;
        while (!rsp_valid && (cyc - acc) < LIMIT) begin
            @(negedge clk);
            any_oe = any_oe | clk_oe | data_oe;
        end
        lat = cyc - acc + 1;
        r_nack = rsp_nack; r_arb = rsp_arb; r_err = rsp_err; r_data = rsp_data;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input logic a);
        issue(op, d, a);
        wait_rsp();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time exceeded, run did not complete");
        $fatal(1, "watchdog");
    end

    logic [1:0] eops [3];
    logic [7:0] b, last_rd;
    logic       a;
    int         s0, st0, c;

    initial begin
        eops[0] = OP_WRITE; eops[1] = OP_STOP; eops[2] = OP_READ;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_flags", {rsp_nack, rsp_arb, rsp_err}, 0);
        chk("rst_data", rsp_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_oe", {clk_oe, data_oe}, 0);
        rst_n = 1'b1;
        starts = 0; stops = 0; bitq.delete();

        // Illegal commands while idle
        for (int i = 0; i < 3; i++) begin
            do_cmd(eops[i], 8'($urandom), 1'($urandom));
            chk("err_lat", lat, 1);
            chk("err_flag", r_err, 1);
            chk("err_no_oe", any_oe, 0);
        end
        @(negedge clk);
        chk("err_ready_next", cmd_ready, 1);
        chk("err_no_bus", starts + stops + bitq.size(), 0);

        do_cmd(OP_START, 8'h00, 1'b0);
        chk("start_lat", lat, LAT_SS);
        chk("start_err", r_err, 0);
        chk("start_busy", busy, 1);
        chk("start_seen", starts, 1);

        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom);
            slave_ack = (i == 0) ? 1'b1 : 1'($urandom);
            mode = M_WACK; bitq.delete();
            do_cmd(OP_WRITE, b, 1'b0);
            mode = M_NONE;
            chk("wr_lat", lat, LAT_BYTE);
            chk("wr_nack", r_nack, !slave_ack);
            chk("wr_arb_err", {r_arb, r_err}, 0);
            chk("wr_nbits", bitq.size(), 9);
            chk("wr_bits", qval(), {b, !slave_ack});
            chk("wr_data_hold", r_data, 8'h00);
        end

        for (int i = 0; i < 3; i++) begin
            rd_byte = (i == 0) ? 8'h3C : 8'($urandom);
            a = (i == 0) ? 1'b0 : 1'($urandom);
            mode = M_READ; bitq.delete();
            do_cmd(OP_READ, 8'h00, a);
            mode = M_NONE;
            chk("rd_lat", lat, LAT_BYTE);
            chk("rd_data", r_data, rd_byte);
            chk("rd_bits", qval(), {rd_byte, !a});
        end
        last_rd = rd_byte;

        mode = M_WACK; slave_ack = 1'b1;
        do_cmd(OP_WRITE, 8'($urandom), 1'b0);
        mode = M_NONE;
        chk("rd_data_hold", r_data, last_rd);
        @(negedge clk);
        chk("ready_after_rsp", cmd_ready, 1);

        s0 = starts; st0 = stops;
        do_cmd(OP_START, 8'h00, 1'b0);
        chk("rstart_lat", lat, LAT_SS);
        chk("rstart_seen", starts, s0 + 1);
        chk("rstart_no_stop", stops, st0);
        chk("rstart_busy", busy, 1);

        do_cmd(OP_STOP, 8'h00, 1'b0);
        chk("stop_lat", lat, LAT_SS);
        chk("stop_seen", stops, st0 + 1);
        chk("stop_busy", busy, 0);
        chk("stop_oe", {clk_oe, data_oe}, 0);

        // Arbitration loss: a competing master pulls SDA low on a '1' bit
        for (int i = 0; i < 2; i++) begin
            do_cmd(OP_START, 8'h00, 1'b0);
            arb_idx = (i == 0) ? 1 : int'($urandom_range(0, 7));
            mode = M_ARB; bitq.delete();
            do_cmd(OP_WRITE, 8'hFF, 1'b0);
            chk("arb_flag", r_arb, 1);
            chk("arb_lat", lat, 4 * D * arb_idx + 3 * D + 1 + (arb_idx + 1) * SX);
            chk("arb_bits", qval(), (1 << (arb_idx + 1)) - 2);
            chk("arb_oe", {clk_oe, data_oe}, 0);
            chk("arb_busy", busy, 0);
            mode = M_NONE;
            @(negedge clk);
        end

`ifdef I2C_MASTER_STRETCH_EN
        do_cmd(OP_START, 8'h00, 1'b0);
        b = 8'($urandom); slave_ack = 1'b1;
        mode = M_WACK; bitq.delete();
        issue(OP_WRITE, b, 1'b0);
        c = 0;
        while (idx != 3 && c < LIMIT) begin @(posedge clk); c++; end
        chk("stretch_bit3_seen", c < LIMIT, 1);
        sl_scl_low = 1'b1;
        repeat (2 * D + 50) @(posedge clk);
        sl_scl_low = 1'b0;
        wait_rsp();
        mode = M_NONE;
        chk("stretch_lat_ge", lat >= LAT_BYTE + 50, 1);
        chk("stretch_bits", qval(), {b, 1'b0});
        chk("stretch_nack", r_nack, 0);
        do_cmd(OP_STOP, 8'h00, 1'b0);
`endif

        // Reset in the middle of a WRITE byte
        do_cmd(OP_START, 8'h00, 1'b0);
        mode = M_WACK;
        issue(OP_WRITE, 8'($urandom), 1'b0);
        c = 0;
        while (idx != 4 && c < LIMIT) begin @(posedge clk); c++; end
        chk("rst_bit4_seen", c < LIMIT, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_oe", {clk_oe, data_oe}, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        rst_n = 1'b1;
        mode = M_NONE;
        s0 = starts;
        do_cmd(OP_START, 8'h00, 1'b0);
        chk("post_rst_start_lat", lat, LAT_SS);
        chk("post_rst_start_seen", starts, s0 + 1);
        chk("post_rst_busy", busy, 1);
        do_cmd(OP_STOP, 8'h00, 1'b0);
        chk("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
